// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
// Lock support is enabled by defining UART_ARB_LOCK_EN.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int DEF_START_TIMEOUT = 4;

  function automatic logic [1:0] onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_arb_rr2.sv
// Two-way round-robin picker; a held lock restricts the win to its owner.
// Purely combinational, gating by FSM state is done in the caller.
module uart_arb_rr2
  import uart_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_i,
  input  logic       lock_active_i,
  input  logic       lock_owner_i,
  output logic [1:0] win_o
);

  always_comb begin
    win_o = 2'b00;
    if (lock_active_i) begin
      win_o = valid_i & onehot(lock_owner_i);
    end else if (&valid_i) begin
      win_o = onehot(~last_i);
    end else begin
      win_o = valid_i;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte requesters, one byte in flight.
// Define UART_ARB_LOCK_EN to let a requester hold ownership across bytes.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int START_TIMEOUT = DEF_START_TIMEOUT,
  parameter int TO_W          = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_lock,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_lock,
  output logic       req1_ready,
  output logic       uart_transmit,
  output logic [7:0] uart_tx_byte,
  input  logic       uart_is_transmitting,
  output logic [1:0] grant,
  output logic       start_err
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(START_TIMEOUT);

  state_e          state_q;
  logic [1:0]      grant_q;
  logic [7:0]      byte_q;
  logic            xmit_q;
  logic            last_q;
  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  logic       lock_active;
  logic       lock_owner;
  logic [1:0] win;
  logic [1:0] ready;
  logic       idle_ok;
  logic       xfer;
  logic       timeout;

  assign cnt_d   = cnt_q + 1'b1;
  assign timeout = (state_q == WAIT_START) && !uart_is_transmitting
                   && (cnt_d == TO_LIM) && !rst;
  assign idle_ok = (state_q == IDLE) && !uart_is_transmitting && !rst;
  assign ready   = idle_ok ? win : 2'b00;
  assign xfer    = |ready;

  uart_arb_rr2 u_rr (
    .valid_i       ({req1_valid, req0_valid}),
    .last_i        (last_q),
    .lock_active_i (lock_active),
    .lock_owner_i  (lock_owner),
    .win_o         (win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      byte_q  <= 8'h00;
      xmit_q  <= 1'b0;
      last_q  <= REQ1;
      cnt_q   <= '0;
    end else begin
      xmit_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            byte_q  <= ready[1] ? req1_data : req0_data;
            grant_q <= ready;
            xmit_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          if (uart_is_transmitting) begin
            state_q <= WAIT_DONE;
          end else if (timeout) begin
            grant_q <= 2'b00;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_DONE: begin
          if (!uart_is_transmitting) begin
            last_q  <= grant_q[1];
            grant_q <= 2'b00;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic lock_q;
  logic lock_own_q;
  logic own_lock;
  logic done_lock;

  assign own_lock    = lock_own_q ? req1_lock : req0_lock;
  assign done_lock   = grant_q[1] ? req1_lock : req0_lock;
  assign lock_active = lock_q && own_lock;
  assign lock_owner  = lock_own_q;

  // Lock drops as soon as the owner releases it in IDLE, so RR applies then.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_own_q <= REQ0;
    end else if ((state_q == WAIT_DONE) && !uart_is_transmitting && done_lock) begin
      lock_q     <= 1'b1;
      lock_own_q <= grant_q[1];
    end else if (timeout || ((state_q == IDLE) && lock_q && !own_lock)) begin
      lock_q <= 1'b0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = req0_lock ^ req1_lock;
  assign lock_active = 1'b0;
  assign lock_owner  = REQ0;
`endif

  assign req0_ready    = ready[0];
  assign req1_ready    = ready[1];
  assign uart_transmit = xmit_q;
  assign uart_tx_byte  = byte_q;
  assign grant         = grant_q;
  assign start_err     = timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple UART busy model.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_lock = 1'b0;
  logic       req1_valid = 1'b0, req1_lock = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       uart_transmit, start_err;
  logic [7:0] uart_tx_byte;
  logic [1:0] grant;
  logic       busy;

  logic       mbusy = 1'b0;
  logic       ext_busy = 1'b0;
  logic       model_en = 1'b0;
  int         left = 0;
  int         viol = 0;
  logic [7:0] txlog[$];

  int checks = 0;
  int errors = 0;

  assign busy = mbusy | ext_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .req0_valid           (req0_valid),
    .req0_data            (req0_data),
    .req0_lock            (req0_lock),
    .req0_ready           (req0_ready),
    .req1_valid           (req1_valid),
    .req1_data            (req1_data),
    .req1_lock            (req1_lock),
    .req1_ready           (req1_ready),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (busy),
    .grant                (grant),
    .start_err            (start_err)
  );

  // UART model: busy from the cycle after the pulse, for 40 cycles
  always @(posedge clk) begin
    if (uart_transmit) begin
      txlog.push_back(uart_tx_byte);
      if (busy) viol <= viol + 1;
    end
    if (!model_en) mbusy <= 1'b0;
    else if (uart_transmit) begin
      mbusy <= 1'b1;
      left  <= 39;
    end else if (left > 0) left <= left - 1;
    else mbusy <= 1'b0;
  end

  task automatic do_reset;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wait_quiet;
    int n = 0, q = 0;
    while (q < 3 && n < 300) begin
      @(negedge clk); #1;
      if (!busy && grant == 2'b00) q++; else q = 0;
      n++;
    end
    checks++;
    if (q < 3) begin errors++; $display("FAIL quiet_timeout: got %0d want 3", q); end
  endtask

  task automatic test_reset;
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("FAIL rst_ready: got %b want 00", {req1_ready, req0_ready});
    end
    checks++;
    if (uart_transmit !== 1'b0) begin errors++; $display("FAIL rst_xmit: got %b want 0", uart_transmit); end
    checks++;
    if (uart_tx_byte !== 8'h00) begin errors++; $display("FAIL rst_byte: got %h want 00", uart_tx_byte); end
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
    checks++;
    if (start_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", start_err); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single;
    int n = 0;
    logic bad = 1'b0;
    model_en = 1'b1; txlog.delete();
    @(negedge clk); req0_data = 8'h41; req0_valid = 1'b1; #1;
    while (!req0_ready && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", req0_ready); end
    @(negedge clk); #1;
    checks++;
    if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_once: got %b want 0", req0_ready); end
    checks++;
    if (uart_transmit !== 1'b1 || uart_tx_byte !== 8'h41) begin
      errors++; $display("FAIL single_xmit: got %b/%h want 1/41", uart_transmit, uart_tx_byte);
    end
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", grant); end
    req0_valid = 1'b0;
    n = 0;
    @(negedge clk); #1;
    while (busy && n < 100) begin
      if (grant !== 2'b01) bad = 1'b1;
      @(negedge clk); #1; n++;
    end
    checks++;
    if (bad || busy) begin errors++; $display("FAIL single_hold: got bad=%b busy=%b want 0/0", bad, busy); end
    @(negedge clk); #1;
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL single_release: got %b want 00", grant); end
    checks++;
    if (txlog.size() != 1 || txlog[0] !== 8'h41) begin
      errors++; $display("FAIL single_log: got %0d bytes want 1 of 41", txlog.size());
    end
  endtask

  task automatic test_contention;
    logic [7:0] exp[4];
    int n = 0, v0;
    exp = '{8'h10, 8'h20, 8'h10, 8'h20};
    do_reset();
    v0 = viol; txlog.delete();
    @(negedge clk);
    req0_data = 8'h10; req1_data = 8'h20; req0_valid = 1'b1; req1_valid = 1'b1;
    while (txlog.size() < 4 && n < 1000) begin @(negedge clk); n++; end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (txlog.size() < 4) begin errors++; $display("FAIL cont_count: got %0d want 4", txlog.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (txlog[i] !== exp[i]) begin errors++; $display("FAIL cont_byte%0d: got %h want %h", i, txlog[i], exp[i]); end
    end
    checks++;
    if (viol != v0) begin errors++; $display("FAIL cont_busy_pulse: got %0d want 0", viol - v0); end
    wait_quiet();
  endtask

  task automatic test_stuck;
    int n = 0, pulses = 0, at = 0;
    model_en = 1'b0; txlog.delete();
    @(negedge clk); req0_data = 8'h55; req0_valid = 1'b1; #1;
    while (!req0_ready && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL stuck_ready: got %b want 1", req0_ready); end
    @(negedge clk); req0_valid = 1'b0; #1;
    checks++;
    if (uart_transmit !== 1'b1) begin errors++; $display("FAIL stuck_xmit: got %b want 1", uart_transmit); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      if (start_err) begin pulses++; at = k; end
    end
    checks++;
    if (pulses != 1 || at != 4) begin
      errors++; $display("FAIL stuck_err: got %0d pulses at %0d want 1 at 4", pulses, at);
    end
    model_en = 1'b1; n = 0;
    req1_data = 8'h66; req1_valid = 1'b1; #1;
    while (!req1_ready && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("FAIL stuck_next_ready: got %b want 1", req1_ready); end
    @(negedge clk); req1_valid = 1'b0; #1;
    checks++;
    if (uart_transmit !== 1'b1 || uart_tx_byte !== 8'h66) begin
      errors++; $display("FAIL stuck_next_xmit: got %b/%h want 1/66", uart_transmit, uart_tx_byte);
    end
    wait_quiet();
  endtask

  task automatic test_lock;
    logic [7:0] d1[3];
    logic [7:0] exp[4];
    int n = 0, n1 = 0, v0;
    logic r0done = 1'b0, r0a = 1'b0, r1a;
    d1 = '{8'h61, 8'h62, 8'h63};
`ifdef UART_ARB_LOCK_EN
    exp = '{8'h61, 8'h62, 8'h63, 8'h30};
`else
    exp = '{8'h61, 8'h30, 8'h62, 8'h63};
`endif
    do_reset();
    model_en = 1'b1; txlog.delete(); v0 = viol;
    @(negedge clk);
    req1_data = d1[0]; req1_lock = 1'b1; req1_valid = 1'b1; #1;
    r1a = req1_ready;
    while (!(n1 == 3 && r0done && txlog.size() >= 4) && n < 2000) begin
      @(negedge clk);
      if (r1a) begin
        n1++;
        if (n1 < 3) req1_data = d1[n1];
        else begin req1_valid = 1'b0; req1_lock = 1'b0; end
        if (n1 == 1) begin req0_data = 8'h30; req0_valid = 1'b1; end
      end
      if (r0a) begin req0_valid = 1'b0; r0done = 1'b1; end
      #1;
      r1a = req1_ready; r0a = req0_ready; n++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; req1_lock = 1'b0;
    checks++;
    if (txlog.size() < 4) begin errors++; $display("FAIL lock_count: got %0d want 4", txlog.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (txlog[i] !== exp[i]) begin errors++; $display("FAIL lock_byte%0d: got %h want %h", i, txlog[i], exp[i]); end
    end
    checks++;
    if (viol != v0) begin errors++; $display("FAIL lock_busy_pulse: got %0d want 0", viol - v0); end
    wait_quiet();
  endtask

  task automatic test_reset_mid;
    int n = 0;
    logic bad = 1'b0;
    model_en = 1'b1;
    @(negedge clk); req0_data = 8'hA5; req0_valid = 1'b1; #1;
    while (!req0_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk); req0_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1; req1_data = 8'hBB; req1_valid = 1'b1; #1;
    checks++;
    if (req1_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", req1_ready); end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (grant !== 2'b00 || uart_transmit !== 1'b0 || uart_tx_byte !== 8'h00 || start_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_outputs: got g=%b x=%b b=%h e=%b want 00/0/00/0", grant, uart_transmit, uart_tx_byte, start_err);
    end
    n = 0;
    while (busy && n < 100) begin
      if (req0_ready || req1_ready) bad = 1'b1;
      @(negedge clk); #1; n++;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL mid_busy_ready: got 1 want 0"); end
    checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("FAIL mid_first_free: got %b want 1", req1_ready); end
    @(negedge clk); req1_valid = 1'b0;
    wait_quiet();
  endtask

  task automatic test_busy_idle;
    logic bad = 1'b0;
    @(negedge clk); ext_busy = 1'b1; req0_data = 8'h77; req0_valid = 1'b1;
    repeat (5) begin @(negedge clk); #1; if (req0_ready) bad = 1'b1; end
    checks++;
    if (bad) begin errors++; $display("FAIL busy_ready: got 1 want 0"); end
    @(negedge clk); ext_busy = 1'b0; #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL busy_first_free: got %b want 1", req0_ready); end
    @(negedge clk); req0_valid = 1'b0;
    wait_quiet();
  endtask

  initial begin
    test_reset();
    test_single();
    wait_quiet();
    test_contention();
    test_stuck();
    test_lock();
    test_reset_mid();
    test_busy_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
